vga_bounce_box_gen: RTL and testbench
=====================================

Name: vga_bounce_box_gen

Overview:
- Pixel-content source feeding the VGA output stage.
- Consumes the raw horizontal/vertical timing counters and the pixel-clock enable from the sync/timing logic.
- Produces registered 1-bit r/g/b for one square box that bounces inside the 640x480 active area, over a solid background.
- Box position updates once per frame. The box colour rotates on every wall bounce.

Parameters:
- H_TOTAL, 800, horizontal counter period (h_cnt wraps at H_TOTAL-1)
- V_TOTAL, 525, vertical counter period
- H_ACT_START, 144, first active h_cnt value
- V_ACT_START, 35, first active v_cnt value
- H_ACT, 640, active width in pixels
- V_ACT, 480, active height in lines
- BOX_SIZE, 32, box edge length in pixels
- STEP, 2, pixels moved per frame on each axis (1..BOX_SIZE)
- BG_COLOR, 3'b001, {r,g,b} for active pixels outside the box

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_en  in  1  one-cycle pulse per pixel; all state advances only when high
- h_cnt  in  10  horizontal counter, 0..H_TOTAL-1
- v_cnt  in  10  vertical counter, 0..V_TOTAL-1
- pause  in  1  when high, the box position and colour are frozen at frame end
- r  out  1  red, registered
- g  out  1  green, registered
- b  out  1  blue, registered
- frame_tick  out  1  one-clk pulse when the per-frame update is applied
- bounce_cnt  out  8  count of wall bounces, wraps 255->0

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high, and takes priority over pixel_en.
- Reset values: r=g=b=0; frame_tick=0; bounce_cnt=0; box_x=0; box_y=0; dir_x=+; dir_y=+; box_color=3'b100.
- Active region: h_cnt in [H_ACT_START, H_ACT_START+H_ACT) and v_cnt in [V_ACT_START, V_ACT_START+V_ACT).
  - Active coordinates: ax = h_cnt-H_ACT_START, ay = v_cnt-V_ACT_START.
- Box hit: active, and ax in [box_x, box_x+BOX_SIZE), and ay in [box_y, box_y+BOX_SIZE).
- Output pipeline: on a clk edge with pixel_en=1, {r,g,b} <= box hit ? box_color : active ? BG_COLOR : 3'b000.
  - Latency is exactly one pixel_en-qualified edge.
  - With pixel_en=0, the outputs hold.
- Frame end: pixel_en=1 and h_cnt==H_TOTAL-1 and v_cnt==V_TOTAL-1.
  - On that edge frame_tick<=1; on every other edge frame_tick<=0.
  - If pause=1, frame_tick still pulses but position, direction, colour and bounce_cnt hold.
- Motion: X_MAX = H_ACT-BOX_SIZE, Y_MAX = V_ACT-BOX_SIZE. Per axis, at frame end when not paused:
  - dir +: if box+STEP >= MAX, then box<=MAX, dir<=-, bounce on that axis; else box<=box+STEP.
  - dir -: if box <= STEP, then box<=0, dir<=+, bounce on that axis; else box<=box-STEP.
  - Compare before adding/subtracting. Positions use 10-bit arithmetic and must never underflow or exceed MAX.
- Bounce effects (when at least one axis bounces in a frame):
  - bounce_cnt increments by exactly 1, even if both axes bounce (corner).
  - box_color rotates 100->010->001->110->011->101->111->100; exactly one step per frame.
- Position change timing: the new position takes effect from the next frame's first pixel. A frame never renders a mix of two positions.
- Counter inputs: h_cnt/v_cnt values outside range are treated as blanking (output 000). No error flag.
- Reset mid-frame: outputs go to 000 on the reset edge. Rendering resumes with the box at (0,0) from the next pixel_en after reset deasserts.

Test Plan:
- Reset, then drive one full frame with pixel_en every 4th clk. Pixel at h=144,v=35 -> rgb 100. Pixel at h=176,v=35 -> 001. Pixel at h=143 -> 000. Pixel at v=515 -> 000. Output lags by one pixel_en edge.
- Run 3 frames with pause=0 -> 3 frame_tick pulses; box_x=box_y=6 (box visible at ax=6..37, ay=6..37).
- Run to the vertical wall: after frame 224, box_y=448, dir_y flips to -, bounce_cnt=1, colour 010. After frame 225, box_y=446.
- Drive to a simultaneous corner bounce (preload via a run with X_MAX=Y_MAX equivalent, e.g. H_ACT=V_ACT=480) -> both dirs flip, bounce_cnt +1 only, colour advances one step.
- Hold pause=1 across 5 frame ends -> 5 frame_tick pulses; position, colour and bounce_cnt unchanged.
- Assert reset for 1 clk mid-frame with the box at (100,100) -> next clk rgb=000; the next frame renders the box at (0,0) in colour 100 with bounce_cnt=0.

Source files
------------

// File: rtl/vga_bounce_box_gen_if.sv
// Pixel-content link between the VGA timing logic and the bouncing-box generator.
// The timing side drives counters/enable/pause; the generator returns colour and status.
interface vga_bounce_box_gen_if;
  logic       pixel_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       pause;
  logic       r;
  logic       g;
  logic       b;
  logic       frame_tick;
  logic [7:0] bounce_cnt;

  modport master (
    output pixel_en, h_cnt, v_cnt, pause,
    input  r, g, b, frame_tick, bounce_cnt
  );

  modport slave (
    input  pixel_en, h_cnt, v_cnt, pause,
    output r, g, b, frame_tick, bounce_cnt
  );
endinterface

// File: rtl/vga_bounce_box_gen.sv
// Renders one square box bouncing inside the active area over a solid background.
// Position/colour update at the frame-end pixel, so every frame sees a single position.
module vga_bounce_box_gen #(
  parameter int         H_TOTAL     = 800,
  parameter int         V_TOTAL     = 525,
  parameter int         H_ACT_START = 144,
  parameter int         V_ACT_START = 35,
  parameter int         H_ACT       = 640,
  parameter int         V_ACT       = 480,
  parameter int         BOX_SIZE    = 32,
  parameter int         STEP        = 2,
  parameter logic [2:0] BG_COLOR    = 3'b001
) (
  input logic              clk,
  input logic              reset,
  vga_bounce_box_gen_if.slave vif
);

  localparam logic [10:0] H_START_L = 11'(H_ACT_START);
  localparam logic [10:0] H_END_L   = 11'(H_ACT_START + H_ACT);
  localparam logic [10:0] V_START_L = 11'(V_ACT_START);
  localparam logic [10:0] V_END_L   = 11'(V_ACT_START + V_ACT);
  localparam logic [9:0]  BOX_L     = 10'(BOX_SIZE);
  localparam logic [9:0]  STEP_L    = 10'(STEP);
  localparam logic [9:0]  H_LAST_L  = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST_L  = 10'(V_TOTAL - 1);

  logic [2:0]       rgb_reg;
  logic             frame_tick_reg;
  logic [7:0]       bounce_cnt_reg;
  logic [2:0]       color_reg;
  logic [1:0][9:0]  pos_reg;      // [0] = x, [1] = y
  logic [1:0]       dir_neg_reg;  // 1 = moving toward 0
  logic [1:0][9:0]  pos_next;
  logic [1:0]       dir_next;
  logic [1:0]       bounce;
  logic [1:0][9:0]  coord;
  logic [1:0]       hit;

  logic       h_active;
  logic       v_active;
  logic       active;
  logic       frame_end;
  logic [2:0] pix_next;

  assign h_active  = ({1'b0, vif.h_cnt} >= H_START_L) && ({1'b0, vif.h_cnt} < H_END_L);
  assign v_active  = ({1'b0, vif.v_cnt} >= V_START_L) && ({1'b0, vif.v_cnt} < V_END_L);
  assign active    = h_active && v_active;
  assign coord     = {vif.v_cnt - 10'(V_ACT_START), vif.h_cnt - 10'(H_ACT_START)};
  assign frame_end = vif.pixel_en && (vif.h_cnt == H_LAST_L) && (vif.v_cnt == V_LAST_L);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_axis
      localparam logic [9:0] AX_MAX = (gi == 0) ? 10'(H_ACT - BOX_SIZE) : 10'(V_ACT - BOX_SIZE);
      logic at_high;
      logic at_low;

      // Compare before stepping so the position never overshoots MAX or wraps below 0.
      assign at_high       = (pos_reg[gi] + STEP_L) >= AX_MAX;
      assign at_low        = pos_reg[gi] <= STEP_L;
      assign bounce[gi]    = dir_neg_reg[gi] ? at_low : at_high;
      assign dir_next[gi]  = dir_neg_reg[gi] ^ bounce[gi];
      assign pos_next[gi]  = dir_neg_reg[gi] ? (at_low  ? 10'd0  : pos_reg[gi] - STEP_L)
                                             : (at_high ? AX_MAX : pos_reg[gi] + STEP_L);
      assign hit[gi]       = (coord[gi] >= pos_reg[gi]) && (coord[gi] < pos_reg[gi] + BOX_L);
    end
  endgenerate

  assign pix_next = !active   ? 3'b000 :
                    (&hit)    ? color_reg : BG_COLOR;

  function automatic logic [2:0] rotate_color(input logic [2:0] c);
    case (c)
      3'b100:  return 3'b010;
      3'b010:  return 3'b001;
      3'b001:  return 3'b110;
      3'b110:  return 3'b011;
      3'b011:  return 3'b101;
      3'b101:  return 3'b111;
      default: return 3'b100;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_reg        <= 3'b000;
      frame_tick_reg <= 1'b0;
      bounce_cnt_reg <= 8'd0;
      color_reg      <= 3'b100;
      pos_reg        <= '0;
      dir_neg_reg    <= 2'b00;
    end else begin
      frame_tick_reg <= frame_end;
      if (vif.pixel_en) begin
        rgb_reg <= pix_next;
      end
      if (frame_end && !vif.pause) begin
        pos_reg     <= pos_next;
        dir_neg_reg <= dir_next;
        // A corner hit counts as a single bounce event.
        if (|bounce) begin
          bounce_cnt_reg <= bounce_cnt_reg + 8'd1;
          color_reg      <= rotate_color(color_reg);
        end
      end
    end
  end

  assign vif.r          = rgb_reg[2];
  assign vif.g          = rgb_reg[1];
  assign vif.b          = rgb_reg[0];
  assign vif.frame_tick = frame_tick_reg;
  assign vif.bounce_cnt = bounce_cnt_reg;

endmodule

// File: tb/tb_vga_bounce_box_gen.sv
// Directed bench for the bouncing-box generator: a vector table for rendering and
// frame ticks, then hand sequences for wall/corner bounces, pause and mid-frame reset.
module tb_vga_bounce_box_gen;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  vga_bounce_box_gen_if vif ();
  vga_bounce_box_gen_if vif2 ();

  vga_bounce_box_gen dut (
    .clk   (clk),
    .reset (reset),
    .vif   (vif.slave)
  );

  // Square travel range (X_MAX == Y_MAX) so both axes hit their walls together.
  vga_bounce_box_gen #(.H_ACT(480)) dut_sq (
    .clk   (clk),
    .reset (reset),
    .vif   (vif2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] rgb;
    logic       tick;
    logic [7:0] bcnt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [2:0] rgb1();
    return {vif.r, vif.g, vif.b};
  endfunction

  function automatic logic [2:0] rgb2();
    return {vif2.r, vif2.g, vif2.b};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_in(input logic pe, input logic [9:0] h, input logic [9:0] v);
    vif.pixel_en  = pe;
    vif.h_cnt     = h;
    vif.v_cnt     = v;
    vif2.pixel_en = pe;
    vif2.h_cnt    = h;
    vif2.v_cnt    = v;
  endtask

  task automatic set_pause(input logic p);
    vif.pause  = p;
    vif2.pause = p;
  endtask

  // One pixel_en-qualified edge; outputs are sampled 1 time unit after it.
  task automatic step_pix(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    set_in(1'b1, h, v);
    @(posedge clk);
    #1;
  endtask

  // Three clocks without pixel_en, on a blanking coordinate: the outputs must hold.
  task automatic idle3(input logic [2:0] exp_rgb);
    @(negedge clk);
    set_in(1'b0, 10'd0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_rgb", rgb1(), exp_rgb);
    check("tick_clear", vif.frame_tick, 0);
  endtask

  task automatic frame_end();
    step_pix(10'd799, 10'd524);
    check("frame_tick", vif.frame_tick, 1);
    check("frame_tick_sq", vif2.frame_tick, 1);
    idle3(3'b000);
  endtask

  task automatic probe(input string name, input logic [9:0] h, input logic [9:0] v,
                       input logic [2:0] exp_rgb);
    step_pix(h, v);
    check(name, rgb1(), exp_rgb);
    $display("[TB] %s h=%0d v=%0d rgb=%b", name, h, v, rgb1());
    idle3(exp_rgb);
  endtask

  task automatic probe_sq(input string name, input logic [9:0] h, input logic [9:0] v,
                          input logic [2:0] exp_rgb);
    step_pix(h, v);
    check(name, rgb2(), exp_rgb);
    $display("[TB] %s h=%0d v=%0d rgb=%b", name, h, v, rgb2());
    @(negedge clk);
    set_in(1'b0, 10'd0, 10'd0);
  endtask

  task automatic add(input logic [9:0] h, input logic [9:0] v, input logic [2:0] rgb,
                     input logic tick, input logic [7:0] bcnt);
    vec_t e;
    e.h = h; e.v = v; e.rgb = rgb; e.tick = tick; e.bcnt = bcnt;
    tbl.push_back(e);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Box at (0,0), colour 100, background 001.
    add(10'd144, 10'd35,  3'b100, 1'b0, 8'd0);
    add(10'd175, 10'd35,  3'b100, 1'b0, 8'd0);
    add(10'd176, 10'd35,  3'b001, 1'b0, 8'd0);
    add(10'd144, 10'd66,  3'b100, 1'b0, 8'd0);
    add(10'd144, 10'd67,  3'b001, 1'b0, 8'd0);
    add(10'd143, 10'd35,  3'b000, 1'b0, 8'd0);
    add(10'd144, 10'd34,  3'b000, 1'b0, 8'd0);
    add(10'd144, 10'd515, 3'b000, 1'b0, 8'd0);
    add(10'd783, 10'd514, 3'b001, 1'b0, 8'd0);
    add(10'd784, 10'd100, 3'b000, 1'b0, 8'd0);
    add(10'd900, 10'd100, 3'b000, 1'b0, 8'd0);
    add(10'd799, 10'd524, 3'b000, 1'b1, 8'd0);
    // Box at (2,2).
    add(10'd144, 10'd35,  3'b001, 1'b0, 8'd0);
    add(10'd146, 10'd37,  3'b100, 1'b0, 8'd0);
    add(10'd177, 10'd68,  3'b100, 1'b0, 8'd0);
    add(10'd178, 10'd37,  3'b001, 1'b0, 8'd0);
    add(10'd146, 10'd69,  3'b001, 1'b0, 8'd0);
    add(10'd799, 10'd524, 3'b000, 1'b1, 8'd0);
    add(10'd799, 10'd524, 3'b000, 1'b1, 8'd0);
    // Box at (6,6); a non-final pixel on the last column must not tick.
    add(10'd150, 10'd41,  3'b100, 1'b0, 8'd0);
    add(10'd149, 10'd41,  3'b001, 1'b0, 8'd0);
    add(10'd181, 10'd72,  3'b100, 1'b0, 8'd0);
    add(10'd182, 10'd72,  3'b001, 1'b0, 8'd0);
    add(10'd799, 10'd523, 3'b000, 1'b0, 8'd0);
    add(10'd150, 10'd41,  3'b100, 1'b0, 8'd0);

    reset = 1'b1;
    set_in(1'b0, 10'd0, 10'd0);
    set_pause(1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", rgb1(), 0);
    check("reset_tick", vif.frame_tick, 0);
    check("reset_bcnt", vif.bounce_cnt, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step_pix(tbl[i].h, tbl[i].v);
      check($sformatf("vec%0d_rgb", i), rgb1(), tbl[i].rgb);
      check($sformatf("vec%0d_tick", i), vif.frame_tick, tbl[i].tick);
      check($sformatf("vec%0d_bcnt", i), vif.bounce_cnt, tbl[i].bcnt);
      $display("[TB] vec%0d h=%0d v=%0d rgb=%b tick=%0d bcnt=%0d", i, tbl[i].h, tbl[i].v,
               rgb1(), vif.frame_tick, vif.bounce_cnt);
      idle3(tbl[i].rgb);
    end

    // Frame-end coordinates without pixel_en are not a frame end.
    @(negedge clk);
    set_in(1'b0, 10'd799, 10'd524);
    repeat (4) @(posedge clk);
    #1;
    check("no_pe_no_tick", vif.frame_tick, 0);
    probe("no_pe_no_move", 10'd150, 10'd41, 3'b100);

    // Frames 4..223: y reaches 446, no bounce yet.
    for (int f = 4; f <= 223; f++) frame_end();
    check("bcnt_f223", vif.bounce_cnt, 0);
    check("bcnt_sq_f223", vif2.bounce_cnt, 0);

    // Frame 224: y clamps to 448 and bounces; the square instance bounces on both axes.
    frame_end();
    check("bcnt_f224", vif.bounce_cnt, 1);
    check("bcnt_sq_f224", vif2.bounce_cnt, 1);
    probe("wall_in", 10'd592, 10'd483, 3'b010);
    probe("wall_left", 10'd591, 10'd483, 3'b001);
    probe("wall_above", 10'd592, 10'd482, 3'b001);
    probe("wall_corner", 10'd623, 10'd514, 3'b010);
    probe_sq("corner_in", 10'd592, 10'd483, 3'b010);

    // Frame 225: x=450, y=446; square instance at (446,446).
    frame_end();
    check("bcnt_f225", vif.bounce_cnt, 1);
    check("bcnt_sq_f225", vif2.bounce_cnt, 1);
    probe("back_in", 10'd594, 10'd481, 3'b010);
    probe("back_left", 10'd593, 10'd481, 3'b001);
    probe("back_above", 10'd594, 10'd480, 3'b001);
    probe_sq("corner_back_in", 10'd590, 10'd481, 3'b010);
    probe_sq("corner_back_left", 10'd589, 10'd481, 3'b001);
    probe_sq("corner_back_above", 10'd590, 10'd480, 3'b001);

    // Pause across 5 frame ends: ticks still come, nothing else moves.
    set_pause(1'b1);
    for (int f = 0; f < 5; f++) frame_end();
    check("pause_bcnt", vif.bounce_cnt, 1);
    check("pause_bcnt_sq", vif2.bounce_cnt, 1);
    probe("pause_in", 10'd594, 10'd481, 3'b010);
    probe("pause_left", 10'd593, 10'd481, 3'b001);
    probe("pause_above", 10'd594, 10'd480, 3'b001);
    set_pause(1'b0);

    // Bring the box to (100,100) from a fresh start.
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int f = 0; f < 50; f++) frame_end();
    probe("pos100_in", 10'd244, 10'd135, 3'b100);
    probe("pos100_left", 10'd243, 10'd135, 3'b001);

    // Reset mid-frame while a box pixel is presented: reset wins over pixel_en.
    step_pix(10'd244, 10'd135);
    check("pre_reset_rgb", rgb1(), 3'b100);
    @(negedge clk);
    reset = 1'b1;
    set_in(1'b1, 10'd799, 10'd524);
    @(posedge clk);
    #1;
    check("midreset_rgb", rgb1(), 0);
    check("midreset_tick", vif.frame_tick, 0);
    check("midreset_bcnt", vif.bounce_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    set_in(1'b0, 10'd0, 10'd0);
    probe("after_reset_origin", 10'd144, 10'd35, 3'b100);
    probe("after_reset_old", 10'd244, 10'd135, 3'b001);
    check("after_reset_bcnt", vif.bounce_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
